soc_membus_arbiter: RTL



---
 rtl/soc_arb_pkg.sv | 14 +
 rtl/soc_arb_select.sv | 24 ++
 rtl/soc_membus_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/soc_arb_pkg.sv
// Shared types and constants for the two-master SoC memory bus arbiter.
package soc_arb_pkg;

  // Arbiter FSM: either nobody owns the downstream bus, or one master does.
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_t;

  // Master identifiers as stored in the owner register.
  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

endpackage : soc_arb_pkg

// File: rtl/soc_arb_select.sv
// Combinational winner pick between the two upstream masters.
module soc_arb_select
  import soc_arb_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic [1:0] req_i,
  input  logic       lastOwner_i,
  output logic       winner_o,
  output logic       any_o
);

  // A lone requester always wins; a tie goes to whoever did not own last (RR) or to m0 (fixed).
  always_comb begin
    any_o    = |req_i;
    winner_o = ARB_M0;
    if (req_i == 2'b10) begin
      winner_o = ARB_M1;
    end else if (req_i == 2'b11) begin
      winner_o = ROUND_ROBIN ? ~lastOwner_i : ARB_M0;
    end
  end

endmodule : soc_arb_select

// File: rtl/soc_membus_arbiter.sv
// Shares one downstream memory bus between two masters, switching owners only at
// transaction boundaries and always through at least one idle (req low) cycle.
module soc_membus_arbiter
  import soc_arb_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic        clk,
  input  logic        res_n,
  // upstream master 0
  input  logic        m0Req_i,
  input  logic [31:0] m0Addr_i,
  input  logic        m0WriteEn_i,
  input  logic [3:0]  m0ByteEn_i,
  input  logic [31:0] m0WriteData_i,
  output logic [31:0] m0ReadData_o,
  output logic        m0Valid_o,
  // upstream master 1
  input  logic        m1Req_i,
  input  logic [31:0] m1Addr_i,
  input  logic        m1WriteEn_i,
  input  logic [3:0]  m1ByteEn_i,
  input  logic [31:0] m1WriteData_i,
  output logic [31:0] m1ReadData_o,
  output logic        m1Valid_o,
  // downstream slave
  output logic        sReq_o,
  output logic [31:0] sAddr_o,
  output logic        sWriteEn_o,
  output logic [3:0]  sByteEn_o,
  output logic [31:0] sWriteData_o,
  input  logic [31:0] sReadData_i,
  input  logic        sValid_i,
  // current owner, one-hot
  output logic [1:0]  grant_o
);

  arb_state_t  state_q;
  logic        owner_q;
  logic        lastOwner_q;
  logic [31:0] addrL_q;
  logic        weL_q;
  logic        seenValid_q;

  logic        winner;
  logic        anyReq;
  logic        isOwn;
  logic        ownReq;
  logic [31:0] ownAddr;
  logic        ownWe;
  logic [3:0]  ownBe;
  logic [31:0] ownWd;
  logic        otherReq;
  logic        otherWants;
  logic        targetChanged;
  logic [31:0] winAddr;
  logic        winWe;

  soc_arb_select #(
    .ROUND_ROBIN(ROUND_ROBIN)
  ) uSelect (
    .req_i      ({m1Req_i, m0Req_i}),
    .lastOwner_i(lastOwner_q),
    .winner_o   (winner),
    .any_o      (anyReq)
  );

  // Route the current owner's request fields and decide whether a switch is wanted.
  always_comb begin
    isOwn         = (state_q == ARB_OWN);
    ownReq        = (owner_q == ARB_M1) ? m1Req_i       : m0Req_i;
    ownAddr       = (owner_q == ARB_M1) ? m1Addr_i      : m0Addr_i;
    ownWe         = (owner_q == ARB_M1) ? m1WriteEn_i   : m0WriteEn_i;
    ownBe         = (owner_q == ARB_M1) ? m1ByteEn_i    : m0ByteEn_i;
    ownWd         = (owner_q == ARB_M1) ? m1WriteData_i : m0WriteData_i;
    otherReq      = (owner_q == ARB_M1) ? m0Req_i       : m1Req_i;
    otherWants    = ROUND_ROBIN ? otherReq : (otherReq && (owner_q == ARB_M1));
    targetChanged = (ownAddr != addrL_q) || (ownWe != weL_q);
    winAddr       = (winner == ARB_M1) ? m1Addr_i    : m0Addr_i;
    winWe         = (winner == ARB_M1) ? m1WriteEn_i : m0WriteEn_i;
  end

  // Downstream and grant outputs: pass-through while owned, all zero while idle.
  always_comb begin
    sReq_o       = isOwn & ownReq;
    sAddr_o      = isOwn ? ownAddr : 32'h0;
    sWriteEn_o   = isOwn & ownWe;
    sByteEn_o    = isOwn ? ownBe : 4'h0;
    sWriteData_o = isOwn ? ownWd : 32'h0;
    m0Valid_o    = isOwn && (owner_q == ARB_M0) && sValid_i;
    m1Valid_o    = isOwn && (owner_q == ARB_M1) && sValid_i;
    grant_o      = isOwn ? ((owner_q == ARB_M1) ? 2'b10 : 2'b01) : 2'b00;
  end

  // Only the owner sees the slave's read data; the other master's bus floats.
  assign m0ReadData_o = (isOwn && (owner_q == ARB_M0)) ? sReadData_i : 'z;
  assign m1ReadData_o = (isOwn && (owner_q == ARB_M1)) ? sReadData_i : 'z;

  // Ownership FSM: grant from idle, and release only on drop or at a completed-transaction boundary.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_q     <= ARB_IDLE;
      owner_q     <= ARB_M0;
      lastOwner_q <= ARB_M1;
      addrL_q     <= 32'h0;
      weL_q       <= 1'b0;
      seenValid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (anyReq) begin
            state_q     <= ARB_OWN;
            owner_q     <= winner;
            addrL_q     <= winAddr;
            weL_q       <= winWe;
            seenValid_q <= 1'b0;
          end
        end
        ARB_OWN: begin
          if (!ownReq) begin
            state_q     <= ARB_IDLE;
            lastOwner_q <= owner_q;
          end else if (seenValid_q && targetChanged) begin
            if (otherWants) begin
              state_q     <= ARB_IDLE;
              lastOwner_q <= owner_q;
            end else begin
              addrL_q     <= ownAddr;
              weL_q       <= ownWe;
              seenValid_q <= 1'b0;
            end
          end else if (!seenValid_q && targetChanged) begin
            addrL_q <= ownAddr;
            weL_q   <= ownWe;
          end else if (sValid_i) begin
            seenValid_q <= 1'b1;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule : soc_membus_arbiter
